ctrl_regs_dbuf: RTL and testbench

- Parametrised, multi-channel, double-buffered control-register bank for the I2C transfer datapath.
- Host side writes per-channel SIZE/BRST into shadow registers, then commits them.
- The committed set moves atomically into the active registers driven to the transfer engine. The move happens immediately if the channel's active slot is free, otherwise when the engine consumes the current set.
- Generalises the single-channel size/brst register block to NUM_CH channels, with a commit/consume handshake, status and error reporting.

---
 rtl/ctrl_regs_pkg.sv | 28 ++
 rtl/ctrl_regs_ch.sv | 120 ++++++++++++
 rtl/ctrl_regs_dbuf.sv | 89 ++++++++
 tb/tb_ctrl_regs_dbuf.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_regs_pkg.sv
// Shared register map, CTRL/STATUS bit positions and channel state type for ctrl_regs_dbuf.
// CTRL_REGS_IRQ_EN adds the IE control bit.
package ctrl_regs_pkg;

  localparam logic [1:0] REG_SIZE   = 2'd0;
  localparam logic [1:0] REG_BRST   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_ERR_CLR = 1;
`ifdef CTRL_REGS_IRQ_EN
  localparam int CTRL_IE      = 2;
`endif

  localparam int STAT_VALID     = 0;
  localparam int STAT_PEND      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_STATE_LSB = 3;
  localparam int STAT_IE        = 5;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_PEND = 2'd2
  } ch_state_e;

endpackage

// File: rtl/ctrl_regs_ch.sv
// One channel: shadow/active SIZE+BRST pair, commit/consume FSM and sticky error flag.
// CTRL_REGS_IRQ_EN adds the per-channel IE bit and an interrupt request.
module ctrl_regs_ch
  import ctrl_regs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_size,
  input  logic              wr_brst,
  input  logic              wr_ctrl,
  input  logic [DATA_W-1:0] wdata,
  input  logic              take,
  output logic [DATA_W-1:0] shadow_size,
  output logic [DATA_W-1:0] shadow_brst,
  output logic [DATA_W-1:0] size,
  output logic [DATA_W-1:0] brst,
  output logic              cfg_valid,
  output logic              swap_pulse,
  output logic [DATA_W-1:0] status
`ifdef CTRL_REGS_IRQ_EN
  ,
  output logic              irq_req
`endif
);

  ch_state_e state, state_nxt;
  logic      commit, err_clr, size_zero, locked;
  logic      do_swap, err_set, err, pending;

  assign commit    = wr_ctrl && wdata[CTRL_COMMIT];
  assign err_clr   = wr_ctrl && wdata[CTRL_ERR_CLR];
  assign size_zero = (shadow_size == '0);
  assign locked    = (state == FULL_PEND);
  assign cfg_valid = (state != EMPTY);
  assign pending   = locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // A zero-size commit is rejected everywhere; the shadow set is frozen while a commit is pending.
  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    err_set   = commit && size_zero;
    case (state)
      EMPTY: begin
        if (commit && !size_zero) begin
          do_swap   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (commit && !size_zero) begin
          if (take) do_swap   = 1'b1;
          else      state_nxt = FULL_PEND;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      FULL_PEND: begin
        if (take) begin
          do_swap   = 1'b1;
          state_nxt = FULL;
        end
        if (commit || wr_size || wr_brst) err_set = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_size <= '0;
      shadow_brst <= '0;
      size        <= '0;
      brst        <= '0;
      swap_pulse  <= 1'b0;
      err         <= 1'b0;
    end else begin
      swap_pulse <= do_swap;
      if (do_swap) begin
        size <= shadow_size;
        brst <= shadow_brst;
      end
      if (wr_size && !locked) shadow_size <= wdata;
      if (wr_brst && !locked) shadow_brst <= wdata;
      // Clear first so an error raised by the same CTRL write survives.
      if (err_clr || err_set) err <= err_set;
    end
  end

`ifdef CTRL_REGS_IRQ_EN
  logic ie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ie <= 1'b0;
    else if (wr_ctrl) ie <= wdata[CTRL_IE];
  end

  assign irq_req = (swap_pulse || err) && ie;
`endif

  always_comb begin
    status                         = '0;
    status[STAT_VALID]             = cfg_valid;
    status[STAT_PEND]              = pending;
    status[STAT_ERR]               = err;
    status[STAT_STATE_LSB +: 2]    = state;
`ifdef CTRL_REGS_IRQ_EN
    status[STAT_IE]                = ie;
`else
    status[STAT_IE]                = 1'b0;
`endif
  end

endmodule

// File: rtl/ctrl_regs_dbuf.sv
// Multi-channel double-buffered SIZE/BRST register bank: address decode, rdata mux, channel array.
// CTRL_REGS_IRQ_EN adds the registered irq output.
module ctrl_regs_dbuf
  import ctrl_regs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int DATA_W = 32,
  parameter int ADDR_W = CH_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     write,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH*DATA_W-1:0] size,
  output logic [NUM_CH*DATA_W-1:0] brst,
  output logic [NUM_CH-1:0]        cfg_valid,
  input  logic [NUM_CH-1:0]        cfg_take,
  output logic [NUM_CH-1:0]        swap_pulse
`ifdef CTRL_REGS_IRQ_EN
  ,
  output logic                     irq
`endif
);

  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_off;
  logic [DATA_W-1:0] sh_size [NUM_CH];
  logic [DATA_W-1:0] sh_brst [NUM_CH];
  logic [DATA_W-1:0] status  [NUM_CH];

  assign ch_idx  = addr[ADDR_W-1:2];
  assign reg_off = addr[1:0];

`ifdef CTRL_REGS_IRQ_EN
  logic [NUM_CH-1:0] irq_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_req;
  end
`endif

  // Channel indices at or above NUM_CH match no instance, so their writes vanish.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = write && (int'(ch_idx) == c);

    ctrl_regs_ch #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_size     (hit && (reg_off == REG_SIZE)),
      .wr_brst     (hit && (reg_off == REG_BRST)),
      .wr_ctrl     (hit && (reg_off == REG_CTRL)),
      .wdata       (dataIn),
      .take        (cfg_take[c]),
      .shadow_size (sh_size[c]),
      .shadow_brst (sh_brst[c]),
      .size        (size[c*DATA_W +: DATA_W]),
      .brst        (brst[c*DATA_W +: DATA_W]),
      .cfg_valid   (cfg_valid[c]),
      .swap_pulse  (swap_pulse[c]),
      .status      (status[c])
`ifdef CTRL_REGS_IRQ_EN
      ,
      .irq_req     (irq_req[c])
`endif
    );
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ch_idx) == c) begin
        case (reg_off)
          REG_SIZE:   rdata = sh_size[c];
          REG_BRST:   rdata = sh_brst[c];
          REG_STATUS: rdata = status[c];
          default:    rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_regs_dbuf.sv
// Self-checking bench for ctrl_regs_dbuf: directed scenarios then random traffic against a flag-based model.
module tb_ctrl_regs_dbuf;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [ADDR_W-1:0]        addr = '0;
  logic [DATA_W-1:0]        dataIn = '0;
  logic                     write = 1'b0;
  logic [DATA_W-1:0]        rdata;
  logic [NUM_CH*DATA_W-1:0] size;
  logic [NUM_CH*DATA_W-1:0] brst;
  logic [NUM_CH-1:0]        cfg_valid;
  logic [NUM_CH-1:0]        cfg_take = '0;
  logic [NUM_CH-1:0]        swap_pulse;
`ifdef CTRL_REGS_IRQ_EN
  logic                     irq;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_regs_dbuf #(
    .NUM_CH (NUM_CH),
    .CH_W   (2),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .dataIn     (dataIn),
    .write      (write),
    .rdata      (rdata),
    .size       (size),
    .brst       (brst),
    .cfg_valid  (cfg_valid),
    .cfg_take   (cfg_take),
    .swap_pulse (swap_pulse)
`ifdef CTRL_REGS_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Reference model: each channel is a valid flag plus a pending flag over shadow/active copies.
  logic [31:0]       m_sh_size [NUM_CH];
  logic [31:0]       m_sh_brst [NUM_CH];
  logic [31:0]       m_size    [NUM_CH];
  logic [31:0]       m_brst    [NUM_CH];
  logic              m_valid   [NUM_CH];
  logic              m_pend    [NUM_CH];
  logic              m_err     [NUM_CH];
  logic [NUM_CH-1:0] m_swap;
  logic              m_hit, m_commit, m_clr, m_ok, m_go;
  logic [1:0]        m_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_swap = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_sh_size[c] = 0; m_sh_brst[c] = 0; m_size[c] = 0; m_brst[c] = 0;
        m_valid[c] = 0; m_pend[c] = 0; m_err[c] = 0;
      end
    end else begin
      m_swap = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_hit    = write && (int'(addr[3:2]) == c);
        m_off    = addr[1:0];
        m_commit = m_hit && (m_off == 2'd2) && dataIn[0];
        m_clr    = m_hit && (m_off == 2'd2) && dataIn[1];
        m_ok     = m_commit && (m_sh_size[c] != 0);
        m_go     = 1'b0;
        if (m_clr) m_err[c] = 1'b0;
        if (m_commit && !m_ok) m_err[c] = 1'b1;
        if (m_hit && (m_off < 2'd2)) begin
          if (m_pend[c])          m_err[c] = 1'b1;
          else if (m_off == 2'd0) m_sh_size[c] = dataIn;
          else                    m_sh_brst[c] = dataIn;
        end
        if (m_pend[c]) begin
          if (m_commit) m_err[c] = 1'b1;
          if (cfg_take[c]) begin m_go = 1'b1; m_pend[c] = 1'b0; end
        end else if (m_valid[c]) begin
          if (m_ok && cfg_take[c]) m_go = 1'b1;
          else if (m_ok)           m_pend[c] = 1'b1;
          else if (cfg_take[c])    m_valid[c] = 1'b0;
        end else if (m_ok) begin
          m_go = 1'b1;
          m_valid[c] = 1'b1;
        end
        if (m_go) begin m_size[c] = m_sh_size[c]; m_brst[c] = m_sh_brst[c]; end
        m_swap[c] = m_go;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int         c;
    logic [1:0] code;
    c    = int'(a[3:2]);
    code = m_pend[c] ? 2'd2 : (m_valid[c] ? 2'd1 : 2'd0);
    case (a[1:0])
      2'd0:    return m_sh_size[c];
      2'd1:    return m_sh_brst[c];
      2'd2:    return 32'd0;
      default: return {27'd0, code, m_err[c], m_pend[c], m_valid[c]};
    endcase
  endfunction

  function automatic logic [3:0] addr_of(input int ch, input int off);
    return {ch[1:0], off[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [127:0] es, eb;
    logic [3:0]   ev;
    for (int c = 0; c < NUM_CH; c++) begin
      es[c*32 +: 32] = m_size[c];
      eb[c*32 +: 32] = m_brst[c];
      ev[c]          = m_valid[c];
    end
    chk({tag, ":size"}, size, es);
    chk({tag, ":brst"}, brst, eb);
    chk({tag, ":cfg_valid"}, 128'(cfg_valid), 128'(ev));
    chk({tag, ":swap_pulse"}, 128'(swap_pulse), 128'(m_swap));
  endtask

  task automatic cycle(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] t, input string tag);
    @(negedge clk);
    write = w; addr = a; dataIn = d; cfg_take = t;
    @(posedge clk);
    #1;
    write = 1'b0; cfg_take = '0;
    check_outputs(tag);
  endtask

  task automatic wr(input int ch, input int off, input logic [31:0] d, input string tag);
    cycle(1'b1, addr_of(ch, off), d, 4'b0000, tag);
  endtask

  task automatic rd_expect(input logic [3:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, 128'(rdata), 128'(exp));
    chk({tag, ":model"}, 128'(rdata), 128'(model_read(a)));
  endtask

  initial begin
    int          ch, off;
    logic        w;
    logic [31:0] d;
    logic [3:0]  ra;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst:size", size, '0);
    chk("rst:cfg_valid", 128'(cfg_valid), 128'(0));
    @(posedge clk); #1;
    check_outputs("rst");
    @(negedge clk) rst = 1'b0;
    rd_expect(addr_of(0, 3), 32'd0, "rst:status0");

    // Commit from EMPTY swaps immediately
    wr(0, 0, 32'd10, "c0:size");
    wr(0, 1, 32'd64, "c0:brst");
    wr(0, 2, 32'd1,  "c0:commit");
    chk("c0:size_act", 128'(size[31:0]), 128'(10));
    chk("c0:brst_act", 128'(brst[31:0]), 128'(64));
    chk("c0:valid", 128'(cfg_valid[0]), 128'(1));
    chk("c0:pulse", 128'(swap_pulse[0]), 128'(1));
    cycle(1'b0, 4'd0, 32'd0, 4'b0000, "c0:idle");
    chk("c0:pulse_end", 128'(swap_pulse[0]), 128'(0));

    // Commit while FULL goes pending until the engine takes
    wr(1, 0, 32'd5, "c1:size5");
    wr(1, 2, 32'd1, "c1:commit5");
    wr(1, 0, 32'd7, "c1:size7");
    wr(1, 2, 32'd1, "c1:commit7");
    rd_expect(addr_of(1, 3), 32'd19, "c1:status_pend");
    chk("c1:size_held", 128'(size[63:32]), 128'(5));
    cycle(1'b0, 4'd0, 32'd0, 4'b0010, "c1:take");
    chk("c1:size_swapped", 128'(size[63:32]), 128'(7));
    chk("c1:pulse", 128'(swap_pulse[1]), 128'(1));
    rd_expect(addr_of(1, 3), 32'd9, "c1:status_full");

    // Shadow writes during FULL_PEND are dropped and flag an error
    wr(2, 0, 32'd3, "c2:size3");
    wr(2, 2, 32'd1, "c2:commit3");
    wr(2, 0, 32'd4, "c2:size4");
    wr(2, 2, 32'd1, "c2:commit4");
    wr(2, 0, 32'd99, "c2:size99");
    rd_expect(addr_of(2, 3), 32'd23, "c2:status_err");
    rd_expect(addr_of(2, 0), 32'd4, "c2:shadow_kept");
    wr(2, 2, 32'd2, "c2:errclr");
    rd_expect(addr_of(2, 3), 32'd19, "c2:status_clr");

    // Zero-size commit is rejected
    wr(3, 2, 32'd1, "c3:commit0");
    chk("c3:valid", 128'(cfg_valid[3]), 128'(0));
    rd_expect(addr_of(3, 3), 32'd4, "c3:status");

    // Commit+take on ch0 together with an independent take on ch1
    wr(0, 0, 32'd20, "c0:size20");
    cycle(1'b1, addr_of(0, 2), 32'd1, 4'b0011, "par");
    chk("par:size0", 128'(size[31:0]), 128'(20));
    chk("par:pulse0", 128'(swap_pulse[0]), 128'(1));
    chk("par:valid", 128'(cfg_valid[1:0]), 128'(2'b01));
    rd_expect(addr_of(0, 3), 32'd9, "par:status0");
    rd_expect(addr_of(1, 3), 32'd0, "par:status1");

    // Reset in the middle of a pending set
    wr(1, 0, 32'd8, "c1:size8");
    wr(1, 2, 32'd1, "c1:commit8");
    wr(1, 0, 32'd9, "c1:size9");
    wr(1, 2, 32'd1, "c1:commit9");
    rd_expect(addr_of(1, 3), 32'd19, "mid:status_pend");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid:size", size, '0);
    chk("mid:brst", brst, '0);
    chk("mid:valid", 128'(cfg_valid), 128'(0));
    chk("mid:pulse", 128'(swap_pulse), 128'(0));
    check_outputs("mid");
    @(negedge clk) rst = 1'b0;
    rd_expect(addr_of(1, 3), 32'd0, "mid:status1");
    rd_expect(addr_of(1, 0), 32'd0, "mid:shadow1");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      w   = ($urandom_range(0, 9) < 7);
      ch  = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 3));
      case (off)
        0:       d = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        2:       d = 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      cycle(w, addr_of(ch, off), d, 4'($urandom & $urandom), "rnd");
      ra   = 4'($urandom);
      addr = ra;
      #1;
      chk("rnd:rdata", 128'(rdata), 128'(model_read(ra)));
    end

`ifdef CTRL_REGS_IRQ_EN
    // Swap with IE set gives a one-cycle irq one cycle after swap_pulse
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    wr(0, 0, 32'd1, "irq:size");
    wr(0, 2, 32'd5, "irq:commit_ie");
    @(posedge clk); #1;
    chk("irq:high", 128'(irq), 128'(1));
    @(posedge clk); #1;
    chk("irq:low", 128'(irq), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
